// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_pkg                                                      |
// | Description : Shared types for the sequential ALU. Holds the opcode enum,  |
// |               the flag bit positions, the control FSM state enum and a     |
// |               helper that packs individual flag bits into the 4-bit flag.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'h00,
    OP_SUB  = 5'h01,
    OP_AND  = 5'h02,
    OP_XOR  = 5'h03,
    OP_OR   = 5'h04,
    OP_NOT  = 5'h05,
    OP_SHR1 = 5'h06,
    OP_SHL1 = 5'h07,
    OP_INC  = 5'h08,
    OP_DEC  = 5'h09,
    OP_NAND = 5'h0A,
    OP_NOR  = 5'h0B,
    OP_XNOR = 5'h0C,
    OP_CMP  = 5'h0D,
    OP_NEG  = 5'h0E,
    OP_ROR1 = 5'h0F,
    OP_MUL  = 5'h10,
    OP_SHLB = 5'h11,
    OP_SHRB = 5'h12,
    OP_RORB = 5'h13
  } opcode_e;

  // Bit positions inside the 4-bit flag output
  localparam int c_flag_carry  = 0;
  localparam int c_flag_parity = 1;
  localparam int c_flag_zero   = 2;
  localparam int c_flag_sign   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [3:0] mk_flag(input logic c, input logic p,
                                         input logic z, input logic s);
    logic [3:0] f;
    f                = '0;
    f[c_flag_carry]  = c;
    f[c_flag_parity] = p;
    f[c_flag_zero]   = z;
    f[c_flag_sign]   = s;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_alu_if                                                   |
// | Description : Request/response bundle of the sequential ALU.               |
// |               Request : in_valid, in_ready, opcode, a, b                   |
// |               Response: out_valid, out_ready, out, out_hi, flag            |
// |               master = requester/consumer side, slave = ALU side.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface seq_alu_if #(
  parameter int WIDTH = 8,
  parameter int OPW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_hi;
  logic [3:0]       flag;

  modport master (
    output in_valid, opcode, a, b, out_ready,
    input  in_ready, out_valid, out, out_hi, flag
  );

  modport slave (
    input  in_valid, opcode, a, b, out_ready,
    output in_ready, out_valid, out, out_hi, flag
  );
endinterface
`default_nettype wire

// File: rtl/alu_core_comb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_core_comb                                                |
// | Description : Combinational datapath for all single-cycle opcodes.         |
// |               i_opcode, i_a, i_b : operation and operands                  |
// |               o_res              : result                                  |
// |               o_flag             : {sign, zero, even parity, carry}        |
// |               Opcodes it does not handle (MUL, shift-by-b, 0x14..0x1F)     |
// |               produce res=0, flag=0.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_core_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 5
) (
  input  wire logic [OPW-1:0]   i_opcode,
  input  wire logic [WIDTH-1:0] i_a,
  input  wire logic [WIDTH-1:0] i_b,
  output logic      [WIDTH-1:0] o_res,
  output logic      [3:0]       o_flag
);

  // One extra bit on every add/subtract gives carry or borrow directly
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic [WIDTH:0]   w_neg;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_pz;
  logic             w_c;
  logic             w_s;
  logic             w_v;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_inc  = {1'b0, i_a} + (WIDTH+1)'(1);
  assign w_dec  = {1'b0, i_a} - (WIDTH+1)'(1);
  assign w_neg  = {1'b0, ~i_a} + (WIDTH+1)'(1);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_s   = 1'b0;
    w_v   = 1'b1;
    case (i_opcode)
      OP_ADD:  begin w_res = w_sum[WIDTH-1:0];  w_c = w_sum[WIDTH]; end
      OP_SUB:  begin w_res = w_diff[WIDTH-1:0]; w_c = w_diff[WIDTH]; w_s = w_diff[WIDTH]; end
      OP_AND:  w_res = i_a & i_b;
      OP_XOR:  w_res = i_a ^ i_b;
      OP_OR:   w_res = i_a | i_b;
      OP_NOT:  w_res = ~i_a;
      OP_SHR1: begin w_res = {1'b0, i_a[WIDTH-1:1]}; w_c = i_a[0]; end
      OP_SHL1: begin w_res = {i_a[WIDTH-2:0], 1'b0}; w_c = i_a[WIDTH-1]; end
      OP_INC:  begin w_res = w_inc[WIDTH-1:0]; w_c = w_inc[WIDTH]; end
      OP_DEC:  begin w_res = w_dec[WIDTH-1:0]; w_c = w_dec[WIDTH]; w_s = w_dec[WIDTH]; end
      OP_NAND: w_res = ~(i_a & i_b);
      OP_NOR:  w_res = ~(i_a | i_b);
      OP_XNOR: w_res = ~(i_a ^ i_b);
      // CMP reports nothing in res; its flags describe the difference
      OP_CMP:  begin w_c = w_diff[WIDTH]; w_s = w_diff[WIDTH]; end
      OP_NEG:  begin w_res = w_neg[WIDTH-1:0]; w_c = w_neg[WIDTH]; end
      OP_ROR1: begin w_res = {i_a[0], i_a[WIDTH-1:1]}; w_c = i_a[0]; end
      default: w_v = 1'b0;
    endcase
    w_pz   = (i_opcode == OP_CMP) ? w_diff[WIDTH-1:0] : w_res;
    o_flag = w_v ? mk_flag(w_c, ~^w_pz, ~|w_pz, w_s) : 4'b0000;
  end

  assign o_res = w_res;

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_alu                                                      |
// | Description : Sequential ALU with valid/ready request and response.        |
// |               clk : rising-edge clock                                      |
// |               rst : asynchronous active-high reset                         |
// |               bus : seq_alu_if.slave (in_valid/in_ready/opcode/a/b,        |
// |                     out_valid/out_ready/out/out_hi/flag)                   |
// |               Single-cycle opcodes complete via alu_core_comb; MUL is a    |
// |               WIDTH-step shift-add, shift-by-b moves one bit per cycle.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 5
) (
  input wire logic  clk,
  input wire logic  rst,
  seq_alu_if.slave  bus
);

  localparam int c_cnt_w = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   w_core_res;
  logic [3:0]         w_core_flag;
  logic [WIDTH-1:0]   w_mod;
  logic               w_is_shift;
  logic [WIDTH-1:0]   w_sh;
  logic               w_sh_c;
  logic [WIDTH:0]     w_madd;
  logic [WIDTH-1:0]   w_mhi;
  logic [WIDTH-1:0]   w_mlo;
  logic               w_last;

  state_e             r_state;
  logic [OPW-1:0]     r_op;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_work;   // shift operand, or remaining multiplier bits
  logic [WIDTH-1:0]   r_acc;    // MUL partial-product upper half
  logic [WIDTH-1:0]   r_mcand;  // MUL multiplicand
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out;
  logic [WIDTH-1:0]   r_out_hi;
  logic [3:0]         r_flag;

  alu_core_comb #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_core (
    .i_opcode (bus.opcode),
    .i_a      (bus.a),
    .i_b      (bus.b),
    .o_res    (w_core_res),
    .o_flag   (w_core_flag)
  );

  assign w_mod      = bus.b % WIDTH'(WIDTH);
  assign w_is_shift = bus.opcode inside {OP_SHLB, OP_SHRB, OP_RORB};
  assign w_last     = (r_cnt == c_cnt_w'(1));

  // One bit position per BUSY cycle; carry is the bit leaving this step
  always_comb begin
    w_sh   = r_work;
    w_sh_c = 1'b0;
    case (r_op)
      OP_SHLB: begin w_sh = {r_work[WIDTH-2:0], 1'b0}; w_sh_c = r_work[WIDTH-1]; end
      OP_SHRB: begin w_sh = {1'b0, r_work[WIDTH-1:1]}; w_sh_c = r_work[0]; end
      default: begin w_sh = {r_work[0], r_work[WIDTH-1:1]}; w_sh_c = r_work[0]; end
    endcase
  end

  // Shift-add step: add multiplicand when the current multiplier LSB is set,
  // then shift {acc, multiplier} right by one. After WIDTH steps r_acc holds
  // the upper product half and r_work the lower half.
  assign w_madd = {1'b0, r_acc} + (r_work[0] ? {1'b0, r_mcand} : '0);
  assign w_mhi  = w_madd[WIDTH:1];
  assign w_mlo  = {w_madd[0], r_work[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_cnt       <= '0;
      r_work      <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_hi    <= '0;
      r_flag      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_op       <= bus.opcode;
            r_in_ready <= 1'b0;
            if (bus.opcode == OP_MUL) begin
              r_work  <= bus.b;
              r_mcand <= bus.a;
              r_acc   <= '0;
              r_cnt   <= c_cnt_w'(WIDTH);
              r_state <= ST_BUSY;
            end else if (w_is_shift && (w_mod != '0)) begin
              r_work  <= bus.a;
              r_cnt   <= c_cnt_w'(w_mod);
              r_state <= ST_BUSY;
            end else if (w_is_shift) begin
              // Zero shift count: result is a untouched, nothing shifted out
              r_out       <= bus.a;
              r_out_hi    <= '0;
              r_flag      <= mk_flag(1'b0, ~^bus.a, ~|bus.a, 1'b0);
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_out       <= w_core_res;
              r_out_hi    <= '0;
              r_flag      <= w_core_flag;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end

        ST_BUSY: begin
          r_cnt <= r_cnt - c_cnt_w'(1);
          if (r_op == OP_MUL) begin
            r_acc  <= w_mhi;
            r_work <= w_mlo;
            if (w_last) begin
              r_out       <= w_mlo;
              r_out_hi    <= w_mhi;
              r_flag      <= mk_flag(|w_mhi, ~^w_mlo, ~|{w_mhi, w_mlo}, 1'b0);
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end else begin
            r_work <= w_sh;
            if (w_last) begin
              r_out       <= w_sh;
              r_out_hi    <= '0;
              r_flag      <= mk_flag(w_sh_c, ~^w_sh, ~|w_sh, 1'b0);
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          // Return to IDLE only; acceptance happens from IDLE on a later edge
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.out_hi    = r_out_hi;
  assign bus.flag      = r_flag;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_alu                                                   |
// | Description : Self-checking bench for seq_alu (WIDTH=8). A driver issues   |
// |               directed and random requests and pushes the model's answer   |
// |               into a scoreboard; a monitor compares each presented result. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seq_alu;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W), .OPW(5)) bus ();

  seq_alu #(.WIDTH(W), .OPW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [7:0] o;
    logic [7:0] hi;
    logic [3:0] f;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   bp_mode = 0;  // 0: always ready, 1: random, 2: never ready
  bit   seen  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: opcode semantics written with plain integer arithmetic
  function automatic exp_t model(input int op, input int a, input int b);
    exp_t e;
    int   r, c, s, hi, k, par_src, zero_src;
    bit   v, z_full;
    r = 0; c = 0; s = 0; hi = 0; k = 0; v = 1'b1; z_full = 1'b0;
    par_src = -1;
    e.lat = 1;
    case (op)
      0:  begin r = a + b; c = (r > 255) ? 1 : 0; end
      1:  begin r = a - b; c = (a < b) ? 1 : 0; s = c; end
      2:  r = a & b;
      3:  r = a ^ b;
      4:  r = a | b;
      5:  r = ~a;
      6:  begin r = a >> 1; c = a & 1; end
      7:  begin r = a << 1; c = (a >> 7) & 1; end
      8:  begin r = a + 1; c = (a == 255) ? 1 : 0; end
      9:  begin r = a - 1; c = (a == 0) ? 1 : 0; s = c; end
      10: r = ~(a & b);
      11: r = ~(a | b);
      12: r = ~(a ^ b);
      13: begin par_src = (a - b) & 255; r = 0; c = (a < b) ? 1 : 0; s = c; end
      14: begin r = 256 - a; c = (a == 0) ? 1 : 0; end
      15: begin r = (a >> 1) | (a << 7); c = a & 1; end
      16: begin
        r = a * b; hi = (r >> 8) & 255; c = (hi != 0) ? 1 : 0;
        z_full = (r == 0); e.lat = W + 1;
      end
      17, 18, 19: begin
        k = b % W;
        e.lat = k + 1;
        if (op == 17) begin
          r = a << k;
          c = (k != 0) ? ((a >> (W - k)) & 1) : 0;
        end else if (op == 18) begin
          r = a >> k;
          c = (k != 0) ? ((a >> (k - 1)) & 1) : 0;
        end else begin
          r = (a >> k) | (a << (W - k));
          c = (k != 0) ? ((a >> (k - 1)) & 1) : 0;
        end
      end
      default: v = 1'b0;
    endcase
    r = r & 255;
    if (par_src < 0) par_src = r;
    zero_src = par_src;
    e.o  = v ? 8'(r) : 8'h00;
    e.hi = v ? 8'(hi) : 8'h00;
    if (!v) e.f = 4'b0000;
    else begin
      e.f[0] = c[0];
      e.f[1] = ($countones(par_src) % 2 == 0);
      e.f[2] = (op == 16) ? z_full : (zero_src == 0);
      e.f[3] = s[0];
    end
    e.acc = 0;
    return e;
  endfunction

  task automatic send(input int op, input int a, input int b);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opcode   = 5'(op);
    bus.a        = 8'(a);
    bus.b        = 8'(b);
    n = 0;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("accept_timeout", 64'(n), 64'(0));
    end else begin
      e     = model(op, a, b);
      e.acc = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
    end
    // Scramble operands: the DUT must have captured them already
    bus.in_valid = 1'b0;
    bus.opcode   = 5'($urandom);
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 64'(sb.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  function automatic int pick();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return 255;
      2:       return 1;
      3:       return 128;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // Back-pressure generator
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (bp_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every presented result against the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (bus.out_valid) begin
          chk("in_ready_while_done", 64'(bus.in_ready), 64'(0));
          if (sb.size() == 0) begin
            chk("spurious_out_valid", 64'(bus.out_valid), 64'(0));
          end else begin
            if (!seen) begin
              seen = 1'b1;
              chk("latency", 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
            end
            chk("out", 64'(bus.out), 64'(sb[0].o));
            chk("out_hi", 64'(bus.out_hi), 64'(sb[0].hi));
            chk("flag", 64'(bus.flag), 64'(sb[0].f));
            if (bus.out_ready) begin
              void'(sb.pop_front());
              seen = 1'b0;
            end
          end
        end else if (sb.size() != 0 && cyc >= sb[0].acc) begin
          chk("in_ready_while_busy", 64'(bus.in_ready), 64'(0));
        end
      end
    end
  end

  initial begin
    int op;
    bus.in_valid = 1'b0;
    bus.opcode   = '0;
    bus.a        = '0;
    bus.b        = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out", 64'(bus.out), 64'(0));
    chk("rst_out_hi", 64'(bus.out_hi), 64'(0));
    chk("rst_flag", 64'(bus.flag), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Directed corner cases
    send(0, 'hFF, 'h01);
    send(1, 'h03, 'h05);
    send(16, 'h10, 'h10);
    send(19, 'h81, 'h09);
    send(19, 'h81, 'h08);
    send(13, 'h05, 'h05);
    send(14, 'h00, 'h00);
    send(17, 'h81, 'h0F);
    send(18, 'h81, 'h07);
    send(16, 'hFF, 'hFF);
    send(16, 'h00, 'h37);
    send(21, 'h12, 'h34);
    drain();

    // Random traffic with random back-pressure
    bp_mode = 1;
    repeat (250) begin
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 31))
                                       : int'($urandom_range(0, 19));
      send(op, pick(), pick());
    end
    drain();
    bp_mode = 0;

    // Result held under back-pressure; a request offered meanwhile is ignored
    bp_mode = 2;
    send(0, 'h01, 'h02);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opcode   = 5'h00;
    bus.a        = 8'h09;
    bus.b        = 8'h09;
    repeat (5) @(negedge clk);
    bp_mode      = 0;
    bus.in_valid = 1'b0;
    drain();

    // Reset in the middle of a multiply discards it
    send(16, 'hFF, 'hFF);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    seen = 1'b0;
    #1;
    chk("midrst_out", 64'(bus.out), 64'(0));
    chk("midrst_out_hi", 64'(bus.out_hi), 64'(0));
    chk("midrst_flag", 64'(bus.flag), 64'(0));
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", 64'(bus.in_ready), 64'(1));
    repeat (20) @(negedge clk);
    send(0, 'h10, 'h20);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
